// File: rtl/ldst_ahb_arbiter_if.sv
// Bundle of the two load/store request/response channels and the AHB-Lite master port.
// The arbiter takes the slave view; pipes and the AHB slave model take the master view.
interface ldst_ahb_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_write;
    logic [1:0]        req0_size;
    logic [31:0]       req0_wdata;
    logic              req0_ready;
    logic              resp0_valid;
    logic              resp0_err;
    logic [31:0]       resp0_rdata;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_write;
    logic [1:0]        req1_size;
    logic [31:0]       req1_wdata;
    logic              req1_ready;
    logic              resp1_valid;
    logic              resp1_err;
    logic [31:0]       resp1_rdata;

    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport slave (
        input  req0_valid, req0_addr, req0_write, req0_size, req0_wdata,
        input  req1_valid, req1_addr, req1_write, req1_size, req1_wdata,
        output req0_ready, resp0_valid, resp0_err, resp0_rdata,
        output req1_ready, resp1_valid, resp1_err, resp1_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport master (
        output req0_valid, req0_addr, req0_write, req0_size, req0_wdata,
        output req1_valid, req1_addr, req1_write, req1_size, req1_wdata,
        input  req0_ready, resp0_valid, resp0_err, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_err, resp1_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ldst_ahb_arbiter.sv
// Shares one AHB-Lite master port between the two ME1 load/store pipes: round-robin
// address-phase arbitration, held address phase on wait states, single tracked data phase.
module ldst_ahb_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    ldst_ahb_arbiter_if.slave  bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic        last_grant;
    logic        ap_lock;
    logic        ap_owner;
    logic        dp_valid;
    logic        dp_owner;
    logic        dp_write;
    logic [31:0] dp_wdata;

    logic              err1;
    logic              has_win;
    logic              win;
    logic              drive;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic              win_write;
    logic [1:0]        win_size;
    logic [31:0]       win_wdata;

    // A held address phase keeps its owner even if the other pipe would win the tie.
    always_comb begin
        err1      = dp_valid && bus.HRESP && !bus.HREADY;
        has_win   = 1'b0;
        win       = 1'b0;
        if (ap_lock) begin
            has_win = 1'b1;
            win     = ap_owner;
        end else if (bus.req0_valid && bus.req1_valid) begin
            has_win = 1'b1;
            win     = ~last_grant;
        end else if (bus.req0_valid) begin
            has_win = 1'b1;
            win     = 1'b0;
        end else if (bus.req1_valid) begin
            has_win = 1'b1;
            win     = 1'b1;
        end
        drive  = has_win && !err1;
        accept = drive && bus.HREADY;

        win_addr  = win ? bus.req1_addr  : bus.req0_addr;
        win_write = win ? bus.req1_write : bus.req0_write;
        win_size  = win ? bus.req1_size  : bus.req0_size;
        win_wdata = win ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.HTRANS = drive ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR  = drive ? win_addr : '0;
    assign bus.HWRITE = drive && win_write;
    assign bus.HSIZE  = drive ? {1'b0, win_size} : 3'b000;
    assign bus.HWDATA = (dp_valid && dp_write) ? dp_wdata : 32'h0;

    assign bus.req0_ready = accept && (win == 1'b0);
    assign bus.req1_ready = accept && (win == 1'b1);

    assign bus.resp0_valid = dp_valid && (dp_owner == 1'b0) && bus.HREADY;
    assign bus.resp1_valid = dp_valid && (dp_owner == 1'b1) && bus.HREADY;
    assign bus.resp0_err   = bus.resp0_valid && bus.HRESP;
    assign bus.resp1_err   = bus.resp1_valid && bus.HRESP;
    assign bus.resp0_rdata = (dp_valid && (dp_owner == 1'b0)) ? bus.HRDATA : 32'h0;
    assign bus.resp1_rdata = (dp_valid && (dp_owner == 1'b1)) ? bus.HRDATA : 32'h0;

    // The first ERROR cycle cancels the pending address phase so arbitration restarts cleanly.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_grant <= 1'b1;
            ap_lock    <= 1'b0;
            ap_owner   <= 1'b0;
            dp_valid   <= 1'b0;
            dp_owner   <= 1'b0;
            dp_write   <= 1'b0;
            dp_wdata   <= 32'h0;
        end else if (accept) begin
            last_grant <= win;
            ap_lock    <= 1'b0;
            dp_valid   <= 1'b1;
            dp_owner   <= win;
            dp_write   <= win_write;
            dp_wdata   <= win_wdata;
        end else begin
            if (dp_valid && bus.HREADY) begin
                dp_valid <= 1'b0;
            end
            if (err1) begin
                ap_lock <= 1'b0;
            end else if (drive && !bus.HREADY) begin
                ap_lock  <= 1'b1;
                ap_owner <= win;
            end
        end
    end
endmodule

// File: tb/tb_ldst_ahb_arbiter.sv
// Directed-vector bench for ldst_ahb_arbiter with hand-computed expectations per cycle
// and a monitor enforcing that requesters hold their request until accepted.
module tb_ldst_ahb_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    ldst_ahb_arbiter_if #(.ADDR_W(32)) bus ();

    ldst_ahb_arbiter #(.ADDR_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(
        input bit v0, input logic [31:0] a0, input bit w0, input logic [31:0] d0,
        input bit v1, input logic [31:0] a1, input bit w1, input logic [31:0] d1,
        input bit hready, input bit hresp, input logic [31:0] hrdata);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_write = w0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_write = w1; bus.req1_wdata = d1;
        bus.HREADY = hready; bus.HRESP = hresp; bus.HRDATA = hrdata;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset;
        RST = 1'b0;
        bus.req0_size = 2'd2;
        bus.req1_size = 2'd2;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        RST = 1'b1;
    endtask

    task automatic expAddr(input string t, input logic [1:0] tr, input logic [31:0] a);
        checkOutput({t, ".htrans"}, 64'(bus.HTRANS), 64'(tr));
        checkOutput({t, ".haddr"}, 64'(bus.HADDR), 64'(a));
    endtask

    task automatic expReady(input string t, input bit r0, input bit r1);
        checkOutput({t, ".ready0"}, 64'(bus.req0_ready), 64'(r0));
        checkOutput({t, ".ready1"}, 64'(bus.req1_ready), 64'(r1));
    endtask

    task automatic expResp(input string t, input bit v0, input bit v1, input bit e, input logic [31:0] d);
        checkOutput({t, ".resp0_valid"}, 64'(bus.resp0_valid), 64'(v0));
        checkOutput({t, ".resp1_valid"}, 64'(bus.resp1_valid), 64'(v1));
        if (v0) begin
            checkOutput({t, ".resp0_err"}, 64'(bus.resp0_err), 64'(e));
            checkOutput({t, ".resp0_rdata"}, 64'(bus.resp0_rdata), 64'(d));
            checkOutput({t, ".resp1_rdata"}, 64'(bus.resp1_rdata), 64'h0);
        end
        if (v1) begin
            checkOutput({t, ".resp1_err"}, 64'(bus.resp1_err), 64'(e));
            checkOutput({t, ".resp1_rdata"}, 64'(bus.resp1_rdata), 64'(d));
            checkOutput({t, ".resp0_rdata"}, 64'(bus.resp0_rdata), 64'h0);
        end
    endtask

    // Requesters must not drop or alter a request that has not been accepted yet.
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;
    logic [63:0] held0 = '0;
    logic [63:0] held1 = '0;
    always @(negedge CLK) begin
        if (RST && pend0)
            checkOutput("hold0", {30'd0, bus.req0_valid, bus.req0_write, bus.req0_addr}, held0);
        if (RST && pend1)
            checkOutput("hold1", {30'd0, bus.req1_valid, bus.req1_write, bus.req1_addr}, held1);
        pend0 = RST && bus.req0_valid && !bus.req0_ready;
        pend1 = RST && bus.req1_valid && !bus.req1_ready;
        held0 = {30'd0, bus.req0_valid, bus.req0_write, bus.req0_addr};
        held1 = {30'd0, bus.req1_valid, bus.req1_write, bus.req1_addr};
    end

    initial begin
        doReset();
        #1;
        expAddr("rst", 2'b00, 32'h0);
        checkOutput("rst.hwdata", 64'(bus.HWDATA), 64'h0);
        expReady("rst", 0, 0);
        expResp("rst", 0, 0, 0, 0);

        // Single half-word load from pipe 0.
        bus.req0_size = 2'd1;
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        #1;
        expAddr("ld0.a", 2'b10, 32'h100);
        checkOutput("ld0.a.hsize", 64'(bus.HSIZE), 64'd1);
        checkOutput("ld0.a.hwrite", 64'(bus.HWRITE), 64'd0);
        expReady("ld0.a", 1, 0);
        expResp("ld0.a", 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        #1;
        expAddr("ld0.d", 2'b00, 32'h0);
        expResp("ld0.d", 1, 0, 0, 32'hDEADBEEF);
        tick();

        // Continuous contention: grants alternate 0,1,0,1.
        doReset();
        applyStimulus(1, 32'h200, 0, 0, 1, 32'h300, 0, 0, 1, 0, 32'h0);
        #1;
        expAddr("rr1", 2'b10, 32'h200);
        expReady("rr1", 1, 0);
        expResp("rr1", 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h204, 0, 0, 1, 32'h300, 0, 0, 1, 0, 32'h11111111);
        #1;
        expAddr("rr2", 2'b10, 32'h300);
        expReady("rr2", 0, 1);
        expResp("rr2", 1, 0, 0, 32'h11111111);
        tick();
        applyStimulus(1, 32'h204, 0, 0, 1, 32'h304, 0, 0, 1, 0, 32'h22222222);
        #1;
        expAddr("rr3", 2'b10, 32'h204);
        expReady("rr3", 1, 0);
        expResp("rr3", 0, 1, 0, 32'h22222222);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h304, 0, 0, 1, 0, 32'h33333333);
        #1;
        expAddr("rr4", 2'b10, 32'h304);
        expReady("rr4", 0, 1);
        expResp("rr4", 1, 0, 0, 32'h33333333);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44444444);
        #1;
        expResp("rr5", 0, 1, 0, 32'h44444444);
        tick();

        // Pipe 1 store with two wait states while pipe 0 waits for its address phase.
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 32'h400, 1, 32'hCAFE0001, 1, 0, 32'h0);
        #1;
        expAddr("st.a", 2'b10, 32'h400);
        checkOutput("st.a.hwrite", 64'(bus.HWRITE), 64'd1);
        checkOutput("st.a.hwdata", 64'(bus.HWDATA), 64'h0);
        expReady("st.a", 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0, (i == 2), 0, 32'h0);
            #1;
            checkOutput($sformatf("st.w%0d.hwdata", i), 64'(bus.HWDATA), 64'hCAFE0001);
            expAddr($sformatf("st.w%0d", i), 2'b10, 32'h500);
            expReady($sformatf("st.w%0d", i), (i == 2), 0);
            expResp($sformatf("st.w%0d", i), 0, (i == 2), 0, 32'h0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55);
        #1;
        checkOutput("st.ld.hwdata", 64'(bus.HWDATA), 64'h0);
        expResp("st.ld", 1, 0, 0, 32'h55);
        tick();

        // Held address phase must ignore a pipe that would otherwise win the tie.
        doReset();
        applyStimulus(1, 32'h680, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        #1;
        expReady("lk1", 1, 0);
        tick();
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        expAddr("lk2", 2'b10, 32'h600);
        expReady("lk2", 0, 0);
        expResp("lk2", 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h600, 0, 0, 1, 32'h700, 0, 0, 0, 0, 32'h0);
        #1;
        expAddr("lk3", 2'b10, 32'h600);
        expReady("lk3", 0, 0);
        tick();
        applyStimulus(1, 32'h600, 0, 0, 1, 32'h700, 0, 0, 1, 0, 32'h66);
        #1;
        expAddr("lk4", 2'b10, 32'h600);
        expReady("lk4", 1, 0);
        expResp("lk4", 1, 0, 0, 32'h66);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h700, 0, 0, 1, 0, 32'h77);
        #1;
        expAddr("lk5", 2'b10, 32'h700);
        expReady("lk5", 0, 1);
        expResp("lk5", 1, 0, 0, 32'h77);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88);
        #1;
        expResp("lk6", 0, 1, 0, 32'h88);
        tick();

        // Two-cycle ERROR response with a new request accepted on the second cycle.
        doReset();
        applyStimulus(1, 32'h800, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        #1;
        expReady("er1", 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h900, 0, 0, 0, 1, 32'h0);
        #1;
        expAddr("er2", 2'b00, 32'h0);
        expReady("er2", 0, 0);
        expResp("er2", 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h900, 0, 0, 1, 1, 32'h0);
        #1;
        expAddr("er3", 2'b10, 32'h900);
        expReady("er3", 0, 1);
        expResp("er3", 1, 0, 1, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h99);
        #1;
        expResp("er4", 0, 1, 0, 32'h99);
        tick();

        // Reset during a wait-stated data phase abandons the transfer.
        doReset();
        applyStimulus(1, 32'hA00, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        #1;
        expReady("rm1", 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        expResp("rm2", 0, 0, 0, 0);
        tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hABAB);
        #1;
        expAddr("rm4", 2'b00, 32'h0);
        checkOutput("rm4.hwdata", 64'(bus.HWDATA), 64'h0);
        expResp("rm4", 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'hB00, 0, 0, 1, 32'hC00, 0, 0, 1, 0, 32'h0);
        #1;
        expAddr("rm5", 2'b10, 32'hB00);
        expReady("rm5", 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'hC00, 0, 0, 1, 0, 32'hBB);
        #1;
        expReady("rm6", 0, 1);
        expResp("rm6", 1, 0, 0, 32'hBB);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hCC);
        #1;
        expResp("rm7", 0, 1, 0, 32'hCC);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldst_ahb_arbiter.md
# ldst_ahb_arbiter

Shares one AHB-Lite master port between the two memory-stage load/store requesters (pipe 0 and pipe 1) of the superscalar core. It selects one request per address phase, keeps the AHB address phase stable through wait states, tracks the single outstanding data phase, and routes HRDATA, HREADY and HRESP back to the owning pipe. It sits between the ME1 memory stages and the data-side AHB interconnect.

## Interface
- ADDR_W, 32, address width (data width fixed at 32)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-low reset
- reqN_valid  in  1  pipe N (N=0,1) requests a transfer; held stable until reqN_ready
- reqN_addr  in  ADDR_W  byte address
- reqN_write  in  1  1=store, 0=load
- reqN_size  in  2  0=byte, 1=half, 2=word
- reqN_wdata  in  32  store data, sampled on acceptance
- reqN_ready  out  1  request accepted this cycle (address phase completes)
- respN_valid  out  1  data phase of pipe N's transfer completes this cycle
- respN_err  out  1  completed transfer got an ERROR response
- respN_rdata  out  32  load data (HRDATA passthrough)
- HADDR  out  ADDR_W;  HTRANS  out  2 (IDLE=0, NONSEQ=2 only);  HWRITE  out  1;  HSIZE  out  3 ({1'b0, size});  HWDATA  out  32
- HRDATA  in  32;  HREADY  in  1;  HRESP  in  1

## Operation
- State: last_grant (1 b), ap_lock + ap_owner (address phase held), dp_valid + dp_owner + dp_write + dp_wdata (outstanding data phase).
- Arbitration when not locked: one valid requester wins; both valid -> requester != last_grant wins. last_grant resets to 1, so pipe 0 wins first tie.
- Drive: with a winner, HTRANS=NONSEQ and HADDR/HWRITE/HSIZE from the winner; otherwise HTRANS=IDLE, HADDR/HWRITE/HSIZE=0.
- Acceptance: reqN_ready = winner N && HREADY && !err1, where err1 = dp_valid && HRESP && !HREADY. On acceptance: last_grant<=N, dp_valid<=1, dp_owner<=N, dp_write/dp_wdata captured, ap_lock<=0.
- Wait state: NONSEQ driven with HREADY=0 (not err1) -> ap_lock<=1, ap_owner<=winner; while locked, winner is ap_owner regardless of the other pipe. Requester must not drop/change a request before ready (bench asserts this).
- Error first cycle (err1): HTRANS forced IDLE, no ready, ap_lock<=0 (legal AHB-Lite cancel). Second error cycle (HRESP=1, HREADY=1): respN_valid=1, respN_err=1 for dp_owner; a new request may be accepted the same cycle.
- Data phase: HWDATA = dp_wdata (0 when no store in data phase). respN_valid = dp_valid && dp_owner==N && HREADY; respN_err = that && HRESP; respN_rdata = HRDATA for owner, 0 otherwise. rdata is don't-care for stores but still passed through.
- Completion without new acceptance clears dp_valid; completion with new acceptance reloads dp_* (back-to-back).
- At most one transfer in address phase and one in data phase.

## Timing
- Reset (RST=0 at edge): last_grant=1, ap_lock=0, dp_valid=0, dp_wdata=0. Outputs after reset with no requests: HTRANS=IDLE, HADDR=0, HWDATA=0, all ready/resp=0.
- Reset mid-transfer clears all state; in-flight transfer is abandoned, no response issued.
- ready and resp are combinational from HREADY/HRESP and current state; all state changes on the next edge.
- Zero-wait throughput: one transfer per cycle; accept at T, resp at T+1, alternating owners on continuous contention.
- Wait states extend both the current data phase and the held address phase equally.

## Test plan
- Single load pipe 0, addr 0x100, zero wait, HRDATA=0xDEADBEEF -> ready0 at T, HTRANS=NONSEQ/HADDR=0x100 at T, resp0_valid, rdata=0xDEADBEEF at T+1, resp1_valid never.
- Both pipes valid continuously after reset, zero wait -> grants 0,1,0,1; each resp lands one cycle after its ready on the correct pipe.
- Pipe 1 store 0xCAFE0001 accepted, 2 wait states, pipe 0 raises request during them -> HWDATA=0xCAFE0001 for all 3 data cycles; resp1 on 3rd; pipe 0 address driven and accepted that same cycle.
- Pipe 0 granted with HREADY=0, pipe 1 raises request next cycle -> HADDR/owner stay pipe 0 until HREADY=1 (ap_lock holds).
- Load with ERROR: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE and no ready in cycle 1; resp_valid=1, resp_err=1 in cycle 2.
- RST=0 asserted during a wait-stated data phase -> next cycle HTRANS=IDLE, dp cleared, no resp for the abandoned transfer; next request wins as pipe 0 on tie.
